test_addr_gen: RTL and testbench
================================

TEST_ADDR_GEN -- requirements
Module: test_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, the address bus width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2, the idle cycles after the last issue before done.
REQ-003 SHALL have parameter REP_WIDTH, default 8, the width of the repeat counter.
REQ-004 SHALL have port pll_clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin a sweep.
REQ-007 SHALL have port stall, input, 1, which holds the sweep while high.
REQ-008 SHALL have port last_addr, input, ADDR_WIDTH, the final address of each pass, sampled with start.
REQ-009 SHALL have port repeats, input, REP_WIDTH, the number of extra passes after the first, sampled with start.
REQ-010 SHALL have port addr_out, output, ADDR_WIDTH, the issued address, which feeds the address delay stage.
REQ-011 SHALL have port e_out, output, 1, the enable qualifying addr_out.
REQ-012 SHALL have port busy, output, 1, high in RUN and DRAIN.
REQ-013 SHALL have port done, output, 1, high in DONE.

Function
REQ-014 SHALL implement the states IDLE, RUN, DRAIN and DONE, held in one state register.
REQ-015 SHALL drive every output from a register, with no combinational path from any input to any output.
REQ-016 SHALL, in IDLE or DONE with start=1 at edge N, latch last_addr and repeats, clear the pass counter, and enter RUN with addr_out=0 and e_out=1 visible after edge N+1.
REQ-017 SHALL, in RUN with stall=0, present one address per cycle with e_out=1 and addr_out incrementing by 1.
REQ-018 SHALL, in RUN with stall=1, drive e_out=0 and hold addr_out and the pass counter unchanged; stall takes precedence over the end-of-pass and wrap decisions.
REQ-019 SHALL, when addr_out==last_addr is issued with the pass counter below the latched repeats, wrap addr_out to 0 and increment the pass counter on the next cycle, with no gap in e_out.
REQ-020 SHALL, when addr_out==last_addr is issued with the pass counter equal to the latched repeats, enter DRAIN on the next cycle with e_out=0.
REQ-021 SHALL stay in DRAIN for exactly DRAIN_CYCLES cycles, ignoring stall, and then enter DONE.
REQ-022 SHALL hold DONE with done=1 until start is seen; start in DONE behaves as in REQ-016 and clears done in the same cycle RUN is entered.
REQ-023 SHALL ignore start in RUN and DRAIN, leaving the latched values unchanged.
REQ-024 SHALL treat last_addr=0 as a one-address pass, and last_addr=2^ADDR_WIDTH-1 as a full pass with no arithmetic overflow before the end-of-pass compare.
REQ-025 SHALL issue exactly (repeats+1)*(last_addr+1) cycles with e_out=1 per sweep.
REQ-026 SHALL hold addr_out at its last issued value whenever e_out=0.

Reset
REQ-027 SHALL, with reset_n low, immediately force state=IDLE, addr_out=0, e_out=0, busy=0, done=0, the pass counter to 0, the drain counter to 0 and the latched registers to 0.
REQ-028 SHALL, when reset_n is asserted mid-RUN or mid-DRAIN, abort the sweep with no further e_out pulses and without asserting done.
REQ-029 SHALL resume normal operation on the first rising edge after reset_n deasserts, with start at that edge honoured.

Structure
REQ-030 SHALL take the state encoding (2-bit enum IDLE=0, RUN=1, DRAIN=2, DONE=3) and the parameter defaults from a shared package, test_gen_pkg, which the neighbouring test stages also import.
REQ-031 SHALL be implemented as a single module with no sub-module instances.

Verification
REQ-032 SHALL cover: start with last_addr=3 and repeats=0 -> e_out high for 4 cycles with addrs 0,1,2,3; then 2 idle cycles; then done=1.
REQ-033 SHALL cover: last_addr=1 and repeats=2 -> addr sequence 0,1,0,1,0,1 with e_out continuously high for 6 cycles; then DRAIN; then DONE.
REQ-034 SHALL cover: stall high for 3 cycles while addr_out=5 -> e_out=0 and addr_out=5 held; after release, next issued address is 6; total enabled cycles unchanged.
REQ-035 SHALL cover: stall asserted in the cycle after last_addr is issued -> no wrap and no DRAIN transition until stall drops.
REQ-036 SHALL cover: reset_n pulsed low mid-RUN at addr 7 -> all outputs 0 asynchronously; then start with last_addr=0 -> a single e_out pulse at addr 0, then done.
REQ-037 SHALL cover: start asserted during RUN with different last_addr -> ignored, original sweep length preserved; start in DONE -> new sweep, done drops.

Source files
------------

// File: rtl/test_gen_pkg.sv
// Shared definitions for the test-pattern generator stages.
// State encoding and parameter defaults.
package test_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gen_state_e;

  localparam int ADDR_WIDTH_DEF   = 11;
  localparam int DRAIN_CYCLES_DEF = 2;
  localparam int REP_WIDTH_DEF    = 8;

endpackage

// File: rtl/test_addr_gen.sv
// Address sweep generator: repeated 0..last_addr passes,
// stallable, followed by a fixed drain before done.
module test_addr_gen
  import test_gen_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int REP_WIDTH    = REP_WIDTH_DEF
) (
  input  logic                  pll_clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [REP_WIDTH-1:0]  repeats,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  e_out,
  output logic                  busy,
  output logic                  done
);

  localparam int DLAST =
    (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int DW =
    (DLAST > 0) ? $clog2(DLAST + 1) : 1;

  gen_state_e state_q, state_n;

  logic [ADDR_WIDTH-1:0] addr_n;
  logic [ADDR_WIDTH-1:0] last_q, last_n;
  logic [REP_WIDTH-1:0]  rep_q, rep_n;
  logic [REP_WIDTH-1:0]  pass_q, pass_n;
  logic [DW-1:0]         drain_q, drain_n;
  logic                  fresh_q, fresh_n;
  logic                  e_n;
  logic                  busy_n;
  logic                  done_n;

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_out <= '0;
      e_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      last_q   <= '0;
      rep_q    <= '0;
      pass_q   <= '0;
      drain_q  <= '0;
      fresh_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      addr_out <= addr_n;
      e_out    <= e_n;
      busy     <= busy_n;
      done     <= done_n;
      last_q   <= last_n;
      rep_q    <= rep_n;
      pass_q   <= pass_n;
      drain_q  <= drain_n;
      fresh_q  <= fresh_n;
    end
  end

  // fresh_q marks the cycle after start: address 0 is issued
  // without consulting last_q, so addr_out never steps past it.
  always_comb begin
    state_n = state_q;
    addr_n  = addr_out;
    e_n     = 1'b0;
    last_n  = last_q;
    rep_n   = rep_q;
    pass_n  = pass_q;
    drain_n = drain_q;
    fresh_n = fresh_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          last_n  = last_addr;
          rep_n   = repeats;
          pass_n  = '0;
          drain_n = '0;
          fresh_n = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (fresh_q) begin
            addr_n  = '0;
            e_n     = 1'b1;
            fresh_n = 1'b0;
          end else if (addr_out == last_q) begin
            if (pass_q < rep_q) begin
              addr_n = '0;
              pass_n = pass_q + REP_WIDTH'(1);
              e_n    = 1'b1;
            end else begin
              state_n =
                (DRAIN_CYCLES == 0) ? DONE : DRAIN;
            end
          end else begin
            addr_n = addr_out + ADDR_WIDTH'(1);
            e_n    = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DW'(DLAST)) begin
          state_n = DONE;
        end else begin
          drain_n = drain_q + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN) || (state_n == DRAIN);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_test_addr_gen.sv
// Directed bench for test_addr_gen.
// Drives and samples 1ns after each rising edge.
module tb_test_addr_gen;

  localparam int AW = 11;
  localparam int RW = 8;

  logic          pll_clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          stall;
  logic [AW-1:0] last_addr;
  logic [RW-1:0] repeats;
  logic [AW-1:0] addr_out;
  logic          e_out;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 pll_clock = ~pll_clock;

  test_addr_gen #(
    .ADDR_WIDTH  (AW),
    .DRAIN_CYCLES(2),
    .REP_WIDTH   (RW)
  ) dut (
    .pll_clock(pll_clock),
    .reset_n  (reset_n),
    .start    (start),
    .stall    (stall),
    .last_addr(last_addr),
    .repeats  (repeats),
    .addr_out (addr_out),
    .e_out    (e_out),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pll_clock);
    #1;
  endtask

  task automatic go(input int la, input int rp);
    last_addr = AW'(la);
    repeats   = RW'(rp);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic issue(input string tag, input int a);
    step();
    chk({tag, "_e"}, 32'(e_out), 32'd1);
    chk({tag, "_a"}, 32'(addr_out), 32'(a));
  endtask

  task automatic tail(input string tag);
    step();
    chk({tag, "_d0e"}, 32'(e_out), 32'd0);
    chk({tag, "_d0b"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_d1b"}, 32'(busy), 32'd1);
    chk({tag, "_d1d"}, 32'(done), 32'd0);
    step();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_nbusy"}, 32'(busy), 32'd0);
  endtask

  task automatic sweep(output int n, output int la);
    n  = 0;
    la = -1;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (e_out) begin
        n++;
        la = int'(addr_out);
      end
      if (done) break;
    end
    chk("sweep_end", 32'(done), 32'd1);
  endtask

  int n;
  int la;

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    last_addr = '0;
    repeats   = '0;
    #22;
    chk("rst_a", 32'(addr_out), 32'd0);
    chk("rst_e", 32'(e_out), 32'd0);
    chk("rst_b", 32'(busy), 32'd0);
    chk("rst_d", 32'(done), 32'd0);
    @(negedge pll_clock);
    reset_n = 1'b1;
    step();

    // basic 4-address pass
    go(3, 0);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_e0", 32'(e_out), 32'd0);
    for (int i = 0; i < 4; i++) issue("s1", i);
    tail("s1");
    step();
    chk("s1_hold", 32'(done), 32'd1);

    // repeats, started from DONE
    go(1, 2);
    chk("s2_ndone", 32'(done), 32'd0);
    chk("s2_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) issue("s2", i % 2);
    tail("s2");

    // stall mid-pass
    go(9, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      issue("s3", i);
      n++;
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_st_e", 32'(e_out), 32'd0);
      chk("s3_st_a", 32'(addr_out), 32'd5);
    end
    stall = 1'b0;
    for (int i = 6; i < 10; i++) begin
      issue("s3", i);
      n++;
    end
    chk("s3_cnt", 32'(n), 32'd10);
    tail("s3");

    // stall at end of pass
    go(2, 1);
    for (int i = 0; i < 3; i++) issue("s4", i);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("s4_w_e", 32'(e_out), 32'd0);
      chk("s4_w_a", 32'(addr_out), 32'd2);
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) issue("s4b", i);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_x_e", 32'(e_out), 32'd0);
      chk("s4_x_d", 32'(done), 32'd0);
    end
    stall = 1'b0;
    tail("s4");

    // reset mid-run
    go(15, 0);
    for (int i = 0; i < 8; i++) issue("s5", i);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_ra", 32'(addr_out), 32'd0);
    chk("s5_re", 32'(e_out), 32'd0);
    chk("s5_rb", 32'(busy), 32'd0);
    chk("s5_rd", 32'(done), 32'd0);
    step();
    chk("s5_rlow_e", 32'(e_out), 32'd0);
    @(negedge pll_clock);
    reset_n = 1'b1;
    last_addr = '0;
    repeats   = '0;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("s5_busy", 32'(busy), 32'd1);
    chk("s5_e0", 32'(e_out), 32'd0);
    issue("s5z", 0);
    tail("s5");

    // start during RUN ignored
    go(3, 0);
    issue("s6", 0);
    issue("s6", 1);
    last_addr = AW'(1);
    repeats   = RW'(5);
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("s6_a2", 32'(addr_out), 32'd2);
    sweep(n, la);
    chk("s6_cnt", 32'(n), 32'd1);
    chk("s6_last", 32'(la), 32'd3);

    // full address range
    go((1 << AW) - 1, 0);
    sweep(n, la);
    chk("s7_cnt", 32'(n), 32'd2048);
    chk("s7_last", 32'(la), 32'd2047);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
